// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for blocks that front the registered 16-bit ALU.
package alu_pkg;

    localparam int ALU_DW    = 16;
    localparam int ALU_RW    = 32;
    localparam int ALU_FW    = 4;
    localparam int ALU_FLAGW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational rotating-priority encoder: the first set req bit at or after ptr
// (wrapping mod N) wins.
module alu_rr_grant #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    always_comb begin
        logic [W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one registered ALU among NREQ requesters, with a
// valid/ready request port per requester and one valid/ready response port.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [ALU_DW*NREQ-1:0] req_a,
    input  logic [ALU_DW*NREQ-1:0] req_b,
    input  logic [ALU_FW*NREQ-1:0] req_fun,
    output logic [NREQ-1:0]        req_ready,
    output logic [ALU_DW-1:0]      alu_a,
    output logic [ALU_DW-1:0]      alu_b,
    output logic [ALU_FW-1:0]      alu_fun,
    input  logic [ALU_RW-1:0]      alu_out,
    input  logic [ALU_FLAGW-1:0]   alu_flags,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [ALU_RW-1:0]      resp_data,
    output logic [ALU_FLAGW-1:0]   resp_flags,
    output logic                   busy,
    output arb_state_t             state_dbg
);

    // Handshake rule on both ports: a transfer happens on a rising CLK edge where
    // valid and ready are both high; the sender holds valid and payload until then.

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(ALU_LAT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_nxt;
    logic [CW-1:0]     cnt;
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     grant_idx;
    logic              any_grant;
    logic              accept;
    logic [ALU_DW-1:0] sel_a;
    logic [ALU_DW-1:0] sel_b;
    logic [ALU_FW-1:0] sel_fun;

    alu_rr_grant #(
        .N (NREQ),
        .W (PW)
    ) u_grant (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Only the granted slice reaches the ALU input registers.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_fun = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a   = req_a[i*ALU_DW +: ALU_DW];
                sel_b   = req_b[i*ALU_DW +: ALU_DW];
                sel_fun = req_fun[i*ALU_FW +: ALU_FW];
            end
        end
    end

    assign ptr_nxt = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by RST so no grant is visible while reset is held.
                if (!RST) begin
                    req_ready = grant;
                end
                accept = any_grant;
                if (any_grant) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_fun    <= '0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_flags <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a   <= sel_a;
                alu_b   <= sel_b;
                alu_fun <= sel_fun;
                resp_id <= IDW'(grant_idx);
                ptr     <= ptr_nxt;
                cnt     <= CW'(ALU_LAT);
            end
            // cnt reaches zero exactly when the ALU result for the held inputs is out.
            if (state == WAIT) begin
                if (cnt == '0) begin
                    resp_data  <= alu_out;
                    resp_flags <= alu_flags;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and scoreboard bench for alu_share_arbiter with a behavioural ALU
// behind an ALU_LAT=1 instance and an ALU_LAT=3 instance.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ALU_LAT=1 instance
    logic [NREQ-1:0]      req_valid = '0;
    logic [16*NREQ-1:0]   req_a = '0;
    logic [16*NREQ-1:0]   req_b = '0;
    logic [4*NREQ-1:0]    req_fun = '0;
    logic [NREQ-1:0]      req_ready;
    logic [15:0]          alu_a, alu_b;
    logic [3:0]           alu_fun;
    logic [31:0]          alu_out;
    logic [3:0]           alu_flags;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [IDW-1:0]       resp_id;
    logic [31:0]          resp_data;
    logic [3:0]           resp_flags;
    logic                 busy;
    logic [1:0]           state_dbg;

    // ALU_LAT=3 instance
    logic [NREQ-1:0]      s_req_valid = '0;
    logic [16*NREQ-1:0]   s_req_a = '0;
    logic [16*NREQ-1:0]   s_req_b = '0;
    logic [4*NREQ-1:0]    s_req_fun = '0;
    logic [NREQ-1:0]      s_req_ready;
    logic [15:0]          s_alu_a, s_alu_b;
    logic [3:0]           s_alu_fun;
    logic [31:0]          s_alu_out;
    logic [3:0]           s_alu_flags;
    logic                 s_resp_valid;
    logic                 s_resp_ready = 1'b0;
    logic [IDW-1:0]       s_resp_id;
    logic [31:0]          s_resp_data;
    logic [3:0]           s_resp_flags;
    logic                 s_busy;
    logic [1:0]           s_state_dbg;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .ALU_LAT(1)) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
        .req_ready(req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_flags(resp_flags),
        .busy(busy), .state_dbg(state_dbg)
    );

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .ALU_LAT(3)) dut3 (
        .CLK(clk), .RST(rst),
        .req_valid(s_req_valid), .req_a(s_req_a), .req_b(s_req_b), .req_fun(s_req_fun),
        .req_ready(s_req_ready),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_fun(s_alu_fun),
        .alu_out(s_alu_out), .alu_flags(s_alu_flags),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_id(s_resp_id),
        .resp_data(s_resp_data), .resp_flags(s_resp_flags),
        .busy(s_busy), .state_dbg(s_state_dbg)
    );

    // Behavioural ALU_16bit: returns {arith, logic, cmp, shift, ALU_OUT[31:0]}.
    function automatic logic [35:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] f);
        logic [31:0] r;
        logic [3:0]  fl;
        r  = '0;
        fl = '0;
        case (f)
            4'd0:  begin r = {16'b0, a} + {16'b0, b}; fl = 4'b1000; end
            4'd1:  begin r = {16'b0, a} - {16'b0, b}; fl = 4'b1000; end
            4'd2:  begin r = {16'b0, a} * {16'b0, b}; fl = 4'b1000; end
            4'd3:  begin r = (b != 16'd0) ? {16'b0, a / b} : 32'd0; fl = 4'b1000; end
            4'd4:  begin r = {16'b0, a & b};    fl = 4'b0100; end
            4'd5:  begin r = {16'b0, a | b};    fl = 4'b0100; end
            4'd6:  begin r = {16'b0, ~(a & b)}; fl = 4'b0100; end
            4'd7:  begin r = {16'b0, ~(a | b)}; fl = 4'b0100; end
            4'd8:  begin r = {16'b0, a ^ b};    fl = 4'b0100; end
            4'd9:  begin r = {16'b0, ~(a ^ b)}; fl = 4'b0100; end
            4'd10: begin r = (a == b) ? 32'd1 : 32'd0; fl = 4'b0010; end
            4'd11: begin r = (a > b)  ? 32'd1 : 32'd0; fl = 4'b0010; end
            4'd12: begin r = (a < b)  ? 32'd1 : 32'd0; fl = 4'b0010; end
            4'd13: begin r = {16'b0, a >> 1}; fl = 4'b0001; end
            4'd14: begin r = {16'b0, a << 1}; fl = 4'b0001; end
            default: begin r = '0; fl = '0; end
        endcase
        return {fl, r};
    endfunction

    logic [35:0] m1 = '0;
    logic [35:0] p3_0 = '0, p3_1 = '0, p3_2 = '0;
    always @(posedge clk) begin
        m1   <= alu_model(alu_a, alu_b, alu_fun);
        p3_0 <= alu_model(s_alu_a, s_alu_b, s_alu_fun);
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign alu_out     = m1[31:0];
    assign alu_flags   = m1[35:32];
    assign s_alu_out   = p3_2[31:0];
    assign s_alu_flags = p3_2[35:32];

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_fun[i*4 +: 4] = f;
    endtask

    // Bounded waits; an expired bound shows up in the caller's next comparison.
    task automatic wait_grant();
        for (int n = 0; n < 30 && req_ready == '0; n++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_resp();
        for (int n = 0; n < 30 && resp_valid !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        checks++; if ({alu_a, alu_b, alu_fun} !== 36'h0) begin failures++; $display("FAIL rst_alu: got %h expected 0", {alu_a, alu_b, alu_fun}); end
        checks++; if ({resp_valid, resp_id, resp_data, resp_flags} !== 39'h0) begin failures++; $display("FAIL rst_resp: got %h expected 0", {resp_valid, resp_id, resp_data, resp_flags}); end
        checks++; if ({busy, state_dbg} !== 3'b000) begin failures++; $display("FAIL rst_state: got %b expected 000", {busy, state_dbg}); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL idle_no_valid: got %b expected 0000", req_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        resp_ready = 1'b1;
        set_req(0, 16'h0003, 16'h0004, 4'h0);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if ({alu_a, alu_b, alu_fun} !== {16'd3, 16'd4, 4'd0}) begin failures++; $display("FAIL single_alu_in: got %h expected %h", {alu_a, alu_b, alu_fun}, {16'd3, 16'd4, 4'd0}); end
        checks++; if ({busy, req_ready, resp_valid} !== 6'b100000) begin failures++; $display("FAIL single_wait: got %b expected 100000", {busy, req_ready, resp_valid}); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b expected 0", resp_valid); end
        @(negedge clk); #1;
        checks++; if ({resp_valid, resp_id} !== 3'b100) begin failures++; $display("FAIL single_valid_id: got %b expected 100", {resp_valid, resp_id}); end
        checks++; if ({resp_flags, resp_data} !== {4'b1000, 32'd7}) begin failures++; $display("FAIL single_data: got %h expected %h", {resp_flags, resp_data}, {4'b1000, 32'd7}); end
        @(negedge clk); #1;
        checks++; if ({resp_valid, busy} !== 2'b00) begin failures++; $display("FAIL single_release: got %b expected 00", {resp_valid, busy}); end
        checks++; if (alu_a !== 16'd3) begin failures++; $display("FAIL single_alu_hold: got %h expected 0003", alu_a); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data [NREQ];
        logic [3:0]  exp_fl   [NREQ];
        exp_data = '{32'd3, 32'd2, 32'd1, 32'h40};
        exp_fl   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 16'd5, 16'd2, 4'd1);
        set_req(1, 16'd6, 16'd3, 4'd4);
        set_req(2, 16'd9, 16'd9, 4'd10);
        set_req(3, 16'h0081, 16'd0, 4'd13);
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            wait_grant();
            checks++; if (req_ready !== (4'b0001 << (k % 4))) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'b0001 << (k % 4)); end
            @(negedge clk); #1;
            wait_resp();
            checks++; if ({resp_valid, resp_id} !== {1'b1, 2'(k % 4)}) begin failures++; $display("FAIL rr_id%0d: got %b expected %b", k, {resp_valid, resp_id}, {1'b1, 2'(k % 4)}); end
            checks++; if ({resp_flags, resp_data} !== {exp_fl[k%4], exp_data[k%4]}) begin failures++; $display("FAIL rr_data%0d: got %h expected %h", k, {resp_flags, resp_data}, {exp_fl[k%4], exp_data[k%4]}); end
            if (k == 7) req_valid = '0;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        resp_ready = 1'b0;
        set_req(0, 16'd1, 16'd1, 4'd0);
        req_valid = 4'b0001;
        #1;
        wait_grant();
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant0: got %b expected 0001", req_ready); end
        @(negedge clk);
        set_req(2, 16'd7, 16'd2, 4'd2);
        req_valid = 4'b0100;
        #1;
        wait_resp();
        for (int n = 0; n < 10; n++) begin
            checks++; if ({resp_valid, resp_id, req_ready} !== {1'b1, 2'd0, 4'b0000}) begin failures++; $display("FAIL bp_hold%0d: got %b expected 1000000", n, {resp_valid, resp_id, req_ready}); end
            checks++; if ({resp_flags, resp_data} !== {4'b1000, 32'd2}) begin failures++; $display("FAIL bp_data%0d: got %h expected %h", n, {resp_flags, resp_data}, {4'b1000, 32'd2}); end
            @(negedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hs_cycle_grant: got %b expected 0000", req_ready); end
        @(negedge clk); #1;
        checks++; if ({resp_valid, req_ready} !== 5'b00100) begin failures++; $display("FAIL bp_grant2: got %b expected 00100", {resp_valid, req_ready}); end
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_resp();
        checks++; if ({resp_valid, resp_id, resp_flags, resp_data} !== {1'b1, 2'd2, 4'b1000, 32'd14}) begin failures++; $display("FAIL bp_resp2: got %h expected %h", {resp_valid, resp_id, resp_flags, resp_data}, {1'b1, 2'd2, 4'b1000, 32'd14}); end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_wait();
        bit saw = 1'b0;
        @(negedge clk);
        set_req(1, 16'd10, 16'd5, 4'd1);
        req_valid = 4'b0010;
        #1;
        wait_grant();
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rw_grant1: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        checks++; if ({alu_a, alu_b, alu_fun, resp_id, resp_data, resp_flags} !== 74'h0) begin failures++; $display("FAIL rw_outputs: got %h expected 0", {alu_a, alu_b, alu_fun, resp_id, resp_data, resp_flags}); end
        checks++; if ({resp_valid, busy, state_dbg, req_ready} !== 8'h0) begin failures++; $display("FAIL rw_state: got %b expected 00000000", {resp_valid, busy, state_dbg, req_ready}); end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            saw = saw | resp_valid;
            @(negedge clk);
        end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rw_dropped_op: got %b expected 0", saw); end
        set_req(0, 16'd2, 16'd3, 4'd2);
        set_req(3, 16'd1, 16'd1, 4'd0);
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rw_ptr_reset: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_resp();
        checks++; if ({resp_valid, resp_id, resp_flags, resp_data} !== {1'b1, 2'd0, 4'b1000, 32'd6}) begin failures++; $display("FAIL rw_resp: got %h expected %h", {resp_valid, resp_id, resp_flags, resp_data}, {1'b1, 2'd0, 4'b1000, 32'd6}); end
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int last = 0;
        @(negedge clk);
        resp_ready = 1'b1;
        set_req(0, 16'hFFFF, 16'h0001, 4'd0);
        req_valid = 4'b0001;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL b2b_grant%0d: got %b expected 0001", k, req_ready); end
            if (k > 0) begin
                checks++; if (cyc - last !== 4) begin failures++; $display("FAIL b2b_period%0d: got %0d expected 4", k, cyc - last); end
            end
            last = cyc;
            @(negedge clk); #1;
            wait_resp();
            checks++; if ({resp_valid, resp_id, resp_flags, resp_data} !== {1'b1, 2'd0, 4'b1000, 32'h0001_0000}) begin failures++; $display("FAIL b2b_resp%0d: got %h expected %h", k, {resp_valid, resp_id, resp_flags, resp_data}, {1'b1, 2'd0, 4'b1000, 32'h0001_0000}); end
            if (k == 3) req_valid = '0;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_latency_sweep();
        logic [37:0]     exp_q[$];
        int              acc_q[$];
        bit              act [NREQ];
        logic [15:0]     ra [NREQ];
        logic [15:0]     rb [NREQ];
        logic [3:0]      rf [NREQ];
        logic [NREQ-1:0] acc_mask = '0;
        logic [37:0]     e;
        bit              prev_v = 1'b0;
        int              started = 0, done = 0, mptr = 0, budget = 0, g;
        for (int i = 0; i < NREQ; i++) begin
            act[i] = 1'b0; ra[i] = '0; rb[i] = '0; rf[i] = '0;
        end
        while (done < 2000 && budget < 60000) begin
            @(negedge clk);
            budget++;
            if (s_resp_valid && !prev_v) begin
                checks++;
                if (acc_q.size() == 0 || cyc - acc_q[0] != 5) begin
                    failures++;
                    $display("FAIL sweep_latency: got %0d expected 5", (acc_q.size() == 0) ? -1 : cyc - acc_q[0]);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) act[i] = 1'b0;
                if (!act[i] && started < 2000 && $urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1;
                    ra[i] = 16'($urandom_range(0, 65535));
                    rb[i] = 16'($urandom_range(0, 65535));
                    rf[i] = 4'($urandom_range(0, 15));
                    started++;
                end
                s_req_valid[i] = act[i];
                s_req_a[i*16 +: 16] = ra[i];
                s_req_b[i*16 +: 16] = rb[i];
                s_req_fun[i*4 +: 4] = rf[i];
            end
            acc_mask = '0;
            s_resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (s_req_ready != '0) begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && act[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
                end
                checks++;
                if (g < 0 || s_req_ready !== (4'b0001 << g)) begin
                    failures++;
                    $display("FAIL sweep_grant: got %b expected index %0d", s_req_ready, g);
                end else begin
                    acc_mask[g] = 1'b1;
                    exp_q.push_back({2'(g), alu_model(ra[g], rb[g], rf[g])});
                    acc_q.push_back(cyc);
                    mptr = (g + 1) % NREQ;
                end
            end
            if (s_resp_valid && s_resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sweep_unexpected_resp: got id %0d expected none", s_resp_id);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    if (s_resp_id !== e[37:36]) begin failures++; $display("FAIL sweep_id: got %0d expected %0d", s_resp_id, e[37:36]); end
                    checks++; if (s_resp_data !== e[31:0]) begin failures++; $display("FAIL sweep_data: got %h expected %h", s_resp_data, e[31:0]); end
                    checks++; if (s_resp_flags !== e[35:32]) begin failures++; $display("FAIL sweep_flags: got %b expected %b", s_resp_flags, e[35:32]); end
                end
                done++;
            end
            prev_v = s_resp_valid;
        end
        s_req_valid  = '0;
        s_resp_ready = 1'b0;
        checks++; if (done != 2000) begin failures++; $display("FAIL sweep_timeout: got %0d responses expected 2000", done); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sweep_leftover: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        test_latency_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered ALU_16bit instance between NREQ requesters.
- Each requester sends an operand/function request with a valid/ready handshake.
- The block grants requesters round-robin, drives the ALU inputs, waits the ALU's registered latency, captures ALU_OUT and the four flags, and returns them with the requester ID on a valid/ready response channel.
- It sits between client blocks and the ALU and is the only driver of the ALU's A, B and ALU_FUN inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response ID width; must satisfy 2**IDW >= NREQ.
- ALU_LAT, 1, ALU register stages between input and ALU_OUT (1..4).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  16*NREQ  operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing as req_a.
- req_fun  in  4*NREQ  ALU function code; requester i uses bits [4i+3:4i].
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- alu_a  out  16  to ALU A.
- alu_b  out  16  to ALU B.
- alu_fun  out  4  to ALU ALU_FUN.
- alu_out  in  32  from ALU ALU_OUT.
- alu_flags  in  4  from ALU {arith_flag, logic_flag, cmp_flag, shift_flag}.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  index of the requester served.
- resp_data  out  32  captured ALU_OUT.
- resp_flags  out  4  captured flags, same ordering as alu_flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; round-robin pointer=0, so requester 0 has highest priority.
  - All outputs 0: req_ready, alu_a, alu_b, alu_fun, resp_valid, resp_id, resp_data, resp_flags, busy.
- Reset mid-operation: the in-flight op is dropped and no response is issued. Requesters must re-present after reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational from req_valid and the pointer.
  - Grant goes to the first requester with req_valid set, searching pointer, pointer+1, ... mod NREQ.
  - At most one req_ready bit is high; all are 0 if no req_valid is set.
  - On handshake at the edge:
    - load alu_a, alu_b, alu_fun from the granted slice;
    - latch resp_id=grant;
    - pointer <= grant+1 mod NREQ;
    - cnt <= ALU_LAT;
    - go to WAIT.
- WAIT:
  - req_ready=0. alu_a, alu_b, alu_fun are held stable.
  - cnt decrements each cycle.
  - In the cycle cnt==0, capture resp_data<=alu_out and resp_flags<=alu_flags, then go to RESP.
  - WAIT lasts ALU_LAT+1 cycles.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_flags are stable.
  - On resp_valid & resp_ready, go to IDLE and drop resp_valid next cycle.
  - While resp_ready=0, hold indefinitely (backpressure).
- Latency: request accepted in cycle t gives resp_valid first high in cycle t+ALU_LAT+2. With resp_ready tied high, back-to-back throughput is one op per ALU_LAT+3 cycles.
- resp_ready may already be high when resp_valid rises; the handshake then completes in that first RESP cycle.
- A new request is never accepted in the same cycle as a response handshake; acceptance happens only in IDLE.
- Requesters must hold req_valid and operands until accepted. The block does not sample unaccepted slices.
- alu_* outputs retain the last issued values in IDLE and RESP; they do not return to 0.
- Single-requester case: pointer wrap still applies, so the same requester is re-granted every op.
- resp_id width: the grant index is zero-extended to IDW.

Decomposition:
- Package alu_pkg holds:
  - constants ALU_DW=16, ALU_RW=32, ALU_FW=4, ALU_FLAGW=4;
  - the state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- One sub-module, alu_rr_grant: combinational rotating-priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - It is reused by the team's other shared-resource blocks.

Test Plan:
- Reset during WAIT:
  - Stimulus: assert RST 1 cycle after accepting a req1 request.
  - Response: all outputs 0 immediately; state IDLE; no resp_valid ever appears for that op.
- Single request:
  - Stimulus: req0 A=16'h0003, B=16'h0004, FUN=4'h0, ALU_LAT=1, resp_ready=1.
  - Response: req_ready[0]=1 in cycle t; alu_a=3, alu_b=4 in cycle t+1; resp_valid in cycle t+3 with resp_id=0.
  - resp_data and resp_flags equal the ALU_16bit model's outputs for (3, 4, 0).
- Round-robin:
  - Stimulus: all 4 requesters valid continuously.
  - Response: grant order 0,1,2,3,0; each is granted exactly once per 4 ops.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles after resp_valid rises, with req2 pending.
  - Response: resp_* stable; req_ready stays 0 throughout; req2 is granted in the first IDLE cycle after the handshake.
- Latency sweep:
  - Stimulus: ALU_LAT=3 with a random 2000-op stream (random A, B, FUN, valid and resp_ready).
  - Response: every response matches the scoreboard (id, data, flags); accept-to-valid is exactly 5 cycles.
